// File: rtl/aes_pkg.sv
// Shared AES types: byte/state typedefs and FIPS-197 pack/unpack between 128-bit vectors and state_t.
// Used by aes_shift_rows (optional SROWS_INV_EN inverse mode lives in the users of this package).
package aes_pkg;

  localparam int AES_NB = 4;

  typedef logic [7:0] byte_t;
  // Indexed [row][col]
  typedef byte_t [AES_NB-1:0][AES_NB-1:0] state_t;

  // Byte k of the vector is the top-most byte minus k and maps to s[k mod 4][k div 4]
  function automatic state_t unpack_state(input logic [127:0] vec);
    state_t s;
    s = '0;
    for (int k = 0; k < 16; k++) begin
      s[k[1:0]][k[3:2]] = vec[127-8*k -: 8];
    end
    return s;
  endfunction

  function automatic logic [127:0] pack_state(input state_t s);
    logic [127:0] vec;
    vec = '0;
    for (int k = 0; k < 16; k++) begin
      vec[127-8*k -: 8] = s[k[1:0]][k[3:2]];
    end
    return vec;
  endfunction

endpackage

// File: rtl/aes_shift_rows_comb.sv
// Combinational AES ShiftRows byte permutation on a state_t.
// With SROWS_INV_EN defined, inv_mode=1 selects InvShiftRows (rows rotated right).
module aes_shift_rows_comb
  import aes_pkg::*;
(
`ifdef SROWS_INV_EN
  input  logic   inv_mode,
`endif
  input  state_t in_state,
  output state_t out_state
);

  logic [1:0] src_col;

  // Row r rotates by r bytes; 2-bit wraparound of the column index gives the mod-4
  always_comb begin
    out_state = '0;
    src_col   = '0;
    for (int r = 0; r < AES_NB; r++) begin
      for (int c = 0; c < AES_NB; c++) begin
`ifdef SROWS_INV_EN
        if (inv_mode) begin
          src_col = 2'(c - r);
        end else begin
          src_col = 2'(c + r);
        end
`else
        src_col = 2'(c + r);
`endif
        out_state[r][c] = in_state[r][src_col];
      end
    end
  end

endmodule

// File: rtl/aes_shift_rows.sv
// Registered AES ShiftRows stage: one 128-bit state per srows_enable, one-cycle latency.
// Build option SROWS_INV_EN adds inv_mode for InvShiftRows.
module aes_shift_rows
  import aes_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int NB     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] olddata,
  input  logic              srows_enable,
`ifdef SROWS_INV_EN
  input  logic              inv_mode,
`endif
  output logic              srows_finished,
  output logic [DATA_W-1:0] newdata
);

  if (DATA_W != 128) begin : g_bad_width
    $error("aes_shift_rows: DATA_W must be 128");
  end
  if (NB != AES_NB) begin : g_bad_nb
    $error("aes_shift_rows: NB must be 4");
  end

  state_t in_state;
  state_t shifted_state;

  assign in_state = unpack_state(olddata);

  aes_shift_rows_comb u_comb (
`ifdef SROWS_INV_EN
    .inv_mode  (inv_mode),
`endif
    .in_state  (in_state),
    .out_state (shifted_state)
  );

  // Data register only loads on enable so an idle or undriven olddata never reaches newdata
  always_ff @(posedge clk) begin
    if (rst) begin
      newdata        <= '0;
      srows_finished <= 1'b0;
    end else begin
      srows_finished <= srows_enable;
      if (srows_enable) begin
        newdata <= pack_state(shifted_state);
      end
    end
  end

endmodule

// File: tb/tb_aes_shift_rows.sv
// Scoreboard bench for aes_shift_rows: driver queues expected outputs, monitor compares each cycle.
// Exercises the inverse path when compiled with SROWS_INV_EN.
module tb_aes_shift_rows;

  typedef struct packed {
    logic         finished;
    logic [127:0] data;
    logic [7:0]   tag;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [127:0] olddata;
  logic         srows_enable;
  logic         inv_mode;
  logic         srows_finished;
  logic [127:0] newdata;

  exp_t         exp_q[$];
  int           checks;
  int           failures;
  logic [127:0] model_data;
  logic         model_fin;

  aes_shift_rows #(.DATA_W(128), .NB(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .olddata        (olddata),
    .srows_enable   (srows_enable),
`ifdef SROWS_INV_EN
    .inv_mode       (inv_mode),
`endif
    .srows_finished (srows_finished),
    .newdata        (newdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: byte k sits at row k%4, column k/4; output pulls from the rotated column
  function automatic logic [127:0] ref_shift(input logic [127:0] x, input logic inv);
    logic [127:0] y;
    int r, c, src;
    y = '0;
    for (int k = 0; k < 16; k++) begin
      r   = k % 4;
      c   = k / 4;
      src = inv ? (c - r + 4) % 4 : (c + r) % 4;
      y[127-8*k -: 8] = x[127-8*(r + 4*src) -: 8];
    end
    return y;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive one cycle of inputs and queue what the outputs must be after the next edge
  task automatic applyStimulus(input logic r, input logic en, input logic [127:0] d,
                               input logic inv, input logic use_exp,
                               input logic [127:0] exp_data, input logic [7:0] tag);
    rst          = r;
    srows_enable = en;
    olddata      = d;
    inv_mode     = inv;
    if (r) begin
      model_data = '0;
      model_fin  = 1'b0;
    end else begin
      model_fin = en;
      if (en) model_data = use_exp ? exp_data : ref_shift(d, inv);
    end
    exp_q.push_back('{finished: model_fin, data: model_data, tag: tag});
    @(negedge clk);
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (srows_finished !== e.finished) begin
      failures++;
      $display("[TB] FAIL finished tag=%0d got=%b want=%b", e.tag, srows_finished, e.finished);
    end
    checks++;
    if (newdata !== e.data) begin
      failures++;
      $display("[TB] FAIL newdata tag=%0d got=%h want=%h", e.tag, newdata, e.data);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : driver
    logic [127:0] v;
    logic [127:0] fwd;
    logic         inv_ok;
    int           waited;
    checks    = 0;
    failures  = 0;
    model_data = '0;
    model_fin  = 1'b0;
`ifdef SROWS_INV_EN
    inv_ok = 1'b1;
`else
    inv_ok = 1'b0;
`endif

    // Reset with enable high, then release straight into vector 1
    applyStimulus(1, 1, 128'h112233445566778899AABBCCDDEEFF00, 0, 0, '0, 1);
    applyStimulus(1, 1, 128'h112233445566778899AABBCCDDEEFF00, 0, 0, '0, 2);
    applyStimulus(0, 1, 128'h112233445566778899AABBCCDDEEFF00, 0, 1,
                  128'h1166BB0055AAFF4499EE3388DD2277CC, 3);
    applyStimulus(0, 0, 128'h6677889900AABBCCDDEEFF1122334455, 0, 0, '0, 4);
    applyStimulus(0, 1, 128'h6677889900AABBCCDDEEFF1122334455, 0, 1,
                  128'h66AAFF5500EE4499DD3388CC2277BB11, 5);
    applyStimulus(0, 0, rand128(), 0, 0, '0, 6);

    // Continuous enable with fresh data each cycle
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, rand128(), 0, 0, '0, 8'(10 + i));

    // Reset while enabled discards the pending result
    applyStimulus(1, 1, rand128(), 0, 0, '0, 20);
    applyStimulus(0, 0, rand128(), 0, 0, '0, 21);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), rand128(),
                    0, 0, '0, 8'(30 + i));
    end

    if (inv_ok) begin
      applyStimulus(0, 1, 128'h1166BB0055AAFF4499EE3388DD2277CC, 1, 1,
                    128'h112233445566778899AABBCCDDEEFF00, 80);
      for (int i = 0; i < 10; i++) begin
        v   = rand128();
        fwd = ref_shift(v, 0);
        applyStimulus(0, 1, v,   0, 0, '0, 8'(90 + 2*i));
        applyStimulus(0, 1, fwd, 1, 1, v,  8'(91 + 2*i));
      end
    end

    applyStimulus(0, 0, rand128(), 0, 0, '0, 200);

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain pending=%0d want=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
